// File: rtl/i2c_to_spi.sv
// I2C write-only target that forwards each received data byte to an SPI master (mode 0).
//
// Parameters:
//   SLAVE_ADDR  7-bit I2C address this block ACKs (write direction only)
//   SPI_DIV     clk cycles per SPI SCLK half-period (2..255)
// Ports:
//   clk       system clock, all state on rising edge
//   reset     synchronous active-low reset
//   i2c_scl   I2C clock from the wire (asynchronous)
//   i2c_sda   I2C data from the wire (asynchronous)
//   sda_oe    1 = pull SDA low (ACK)
//   spi_sclk  SPI clock, idle low
//   spi_mosi  SPI data out, MSB first
//   spi_cs_n  SPI chip select, one low pulse per byte
//   busy      holding buffer full or SPI frame in progress
//   ovf       one-clk pulse when a data byte is dropped (NACKed)
module i2c_to_spi #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned SPI_DIV    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i2c_scl,
  input  logic i2c_sda,
  output logic sda_oe,
  output logic spi_sclk,
  output logic spi_mosi,
  output logic spi_cs_n,
  output logic busy,
  output logic ovf
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] DATA_ACK = 3'd4;
  localparam logic [2:0] IGNORE   = 3'd5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(SPI_DIV - 1);

  // Synchronizers plus one extra stage for edge detection
  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] i2c_state_q, i2c_state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ovf_q, ovf_d;
  logic       load;

  logic [7:0] buf_q, buf_d;
  logic       buf_valid_q, buf_valid_d;
  logic       copy;

  logic [2:0] spi_state_q, spi_state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [2:0] spi_bit_q, spi_bit_d;
  logic [7:0] spi_sh_q, spi_sh_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       div_end;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

  // I2C target FSM
  always_comb begin
    i2c_state_d = i2c_state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    ovf_d       = 1'b0;
    load        = 1'b0;
    if (stop_det) begin
      i2c_state_d = IDLE;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
    end else if (start_det) begin
      i2c_state_d = ADDR;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
    end else begin
      case (i2c_state_q)
        ADDR, DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (i2c_state_q == ADDR) begin
              if (shift_q == {SLAVE_ADDR, 1'b0}) begin
                i2c_state_d = ADDR_ACK;
                sda_oe_d    = 1'b1;
              end else begin
                i2c_state_d = IGNORE;
                sda_oe_d    = 1'b0;
              end
            end else if (!buf_valid_q) begin
              load        = 1'b1;
              sda_oe_d    = 1'b1;
              i2c_state_d = DATA_ACK;
            end else begin
              // Buffer still full: drop the byte and leave SDA released (NACK)
              ovf_d    = 1'b1;
              sda_oe_d = 1'b0;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 4'd0;
            i2c_state_d = DATA;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // Load needs valid=0 and copy needs valid=1, so the two never coincide
  always_comb begin
    buf_valid_d = load | (buf_valid_q & ~copy);
    buf_d       = load ? shift_q : buf_q;
  end

  // SPI master FSM: SETUP, 8 x (LOW, HIGH), HOLD, each SPI_DIV clks
  assign div_end = (div_cnt_q == DIV_LAST);

  always_comb begin
    spi_state_d = spi_state_q;
    div_cnt_d   = div_cnt_q;
    spi_bit_d   = spi_bit_q;
    spi_sh_d    = spi_sh_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    copy        = 1'b0;
    case (spi_state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        if (buf_valid_q) begin
          copy        = 1'b1;
          spi_sh_d    = buf_q;
          cs_n_d      = 1'b0;
          div_cnt_d   = 8'd0;
          spi_bit_d   = 3'd0;
          spi_state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          div_cnt_d   = 8'd0;
          spi_state_d = S_LOW;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_LOW: begin
        if (div_end) begin
          div_cnt_d   = 8'd0;
          sclk_d      = 1'b1;
          spi_state_d = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_end) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b0;
          if (spi_bit_q == 3'd7) begin
            spi_state_d = S_HOLD;
          end else begin
            // MOSI only moves on the falling SCLK edge
            spi_bit_d   = spi_bit_q + 3'd1;
            spi_sh_d    = {spi_sh_q[6:0], 1'b0};
            spi_state_d = S_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_cnt_d   = 8'd0;
          cs_n_d      = 1'b1;
          spi_state_d = S_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: spi_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Synchronizers reset to the idle bus level so release creates no false edges
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_prev_q  <= 1'b1;
      i2c_state_q <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      sda_oe_q    <= 1'b0;
      ovf_q       <= 1'b0;
      buf_q       <= 8'd0;
      buf_valid_q <= 1'b0;
      spi_state_q <= S_IDLE;
      div_cnt_q   <= 8'd0;
      spi_bit_q   <= 3'd0;
      spi_sh_q    <= 8'd0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      scl_s1_q    <= i2c_scl;
      scl_s2_q    <= scl_s1_q;
      scl_prev_q  <= scl_s2_q;
      sda_s1_q    <= i2c_sda;
      sda_s2_q    <= sda_s1_q;
      sda_prev_q  <= sda_s2_q;
      i2c_state_q <= i2c_state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      ovf_q       <= ovf_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      spi_state_q <= spi_state_d;
      div_cnt_q   <= div_cnt_d;
      spi_bit_q   <= spi_bit_d;
      spi_sh_q    <= spi_sh_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign ovf      = ovf_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = spi_sh_q[7];
  assign spi_cs_n = cs_n_q;
  assign busy     = buf_valid_q | (spi_state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_to_spi.sv
// Bench for i2c_to_spi: drives I2C write transactions, a monitor decodes SPI frames
// and checks them against a queue of expected bytes.
module tb_i2c_to_spi;

  localparam int unsigned Div      = 4;
  localparam int          FrameLen = 18 * Div;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic sda_oe, spi_sclk, spi_mosi, spi_cs_n, busy, ovf;

  always #5 clk = ~clk;

  i2c_to_spi #(
    .SLAVE_ADDR(7'h50),
    .SPI_DIV   (Div)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .sda_oe  (sda_oe),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .busy    (busy),
    .ovf     (ovf)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  int ack_cnt = 0;
  int ovf_cycles = 0;
  int frame_cnt = 0;
  int cur_bits = 0;
  int low_len = 0;
  logic [7:0] cur_byte = 8'd0;
  logic sclk_prev = 1'b0;
  logic cs_prev = 1'b1;
  logic oe_prev = 1'b0;
  int d = 4;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts ACK assertions and ovf cycles, assembles SPI frames
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur_bits  = 0;
        low_len   = 0;
        sclk_prev = 1'b0;
        cs_prev   = 1'b1;
        oe_prev   = 1'b0;
      end else begin
        if (sda_oe && !oe_prev) ack_cnt++;
        if (ovf) ovf_cycles++;
        if (!spi_cs_n) begin
          low_len++;
          if (spi_sclk && !sclk_prev) begin
            cur_byte = {cur_byte[6:0], spi_mosi};
            cur_bits++;
          end
        end
        if (spi_cs_n && !cs_prev) begin
          frame_cnt++;
          check("frame_len", low_len, FrameLen);
          check("frame_bits", cur_bits, 8);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got byte %02h expected none", cur_byte);
          end else begin
            check("frame_byte", int'(cur_byte), int'(exp_q.pop_front()));
          end
          low_len  = 0;
          cur_bits = 0;
        end
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
        oe_prev   = sda_oe;
      end
    end
  end

  // All bus transitions land 3 ns after a rising clk edge, d clks apart
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic i2c_start();
    sda = 1'b1; tick(d);
    scl = 1'b1; tick(d);
    sda = 1'b0; tick(d);
    scl = 1'b0; tick(d);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; tick(d);
    scl = 1'b1; tick(d);
    sda = 1'b1; tick(d);
  endtask

  task automatic i2c_bit(input logic b);
    sda = b;    tick(d);
    scl = 1'b1; tick(d);
    scl = 1'b0; tick(d);
  endtask

  // Eight data bits then a released ninth (ACK) slot
  task automatic i2c_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    i2c_bit(1'b1);
  endtask

  task automatic begin_test();
    ack_cnt    = 0;
    ovf_cycles = 0;
    frame_cnt  = 0;
  endtask

  task automatic end_test(input string name, input int exp_ack, input int exp_ovf,
                          input int exp_frames);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy && spi_cs_n) break;
    end
    check({name, "_idle_in_time"}, int'(n < 3000), 1);
    repeat (3) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_acks"}, ack_cnt, exp_ack);
    check({name, "_ovf"}, ovf_cycles, exp_ovf);
    check({name, "_frames"}, frame_cnt, exp_frames);
    exp_q.delete();
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    tick(1);
    reset = 1'b1;
    tick(4);

    // Basic write of 0xA5
    begin_test();
    d = 4;
    exp_q.push_back(8'hA5);
    i2c_start(); i2c_byte(8'hA0); i2c_byte(8'hA5); i2c_stop();
    end_test("wr_a5", 2, 0, 1);

    // Wrong address
    begin_test();
    i2c_start(); i2c_byte(8'hA2); i2c_byte(8'h3C); i2c_stop();
    end_test("bad_addr", 0, 0, 0);

    // Read direction is NACKed and the following byte ignored
    begin_test();
    i2c_start(); i2c_byte(8'hA1); i2c_byte(8'h55); i2c_stop();
    end_test("read_dir", 0, 0, 0);

    // Fast back-to-back bytes overflow the single holding buffer
    begin_test();
    d = 1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    i2c_start(); i2c_byte(8'hA0); i2c_byte(8'h01); i2c_byte(8'h02); i2c_byte(8'h03);
    i2c_stop();
    end_test("overflow", 3, 1, 2);

    // Repeated START in the middle of a data byte
    begin_test();
    d = 4;
    exp_q.push_back(8'hFF);
    i2c_start(); i2c_byte(8'hA0);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
    i2c_start(); i2c_byte(8'hA0); i2c_byte(8'hFF); i2c_stop();
    end_test("rep_start", 3, 0, 1);

    // Reset in the middle of an SPI frame aborts it
    begin_test();
    i2c_start(); i2c_byte(8'hA0); i2c_byte(8'h5A); i2c_stop();
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cur_bits >= 4) break;
    end
    check("abort_bit4_reached", int'(cur_bits >= 4), 1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_sda_oe", sda_oe, 0);
    tick(2);
    reset = 1'b1;
    tick(4);
    check("abort_no_frame", frame_cnt, 0);

    begin_test();
    exp_q.push_back(8'h5A);
    i2c_start(); i2c_byte(8'hA0); i2c_byte(8'h5A); i2c_stop();
    end_test("after_reset", 2, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400000 ns");
    $fatal(1, "timeout");
  end

endmodule
